input_conditioner: RTL
======================

Name: input_conditioner

Overview:
- Board-input front end: the input-direction counterpart of the 7-segment display path.
- Takes raw asynchronous buttons and switches (Go, single-step, display-select, clock-rate select) and produces per-channel outputs:
  - synchronized, debounced levels;
  - single-cycle rise and fall pulses.
- Outputs feed the CPU control logic and display/rate selectors in the clk domain.
- Each channel is independent and identical apart from an optional per-channel inversion.

Parameters:
- WIDTH, 8, number of independent input channels.
- DEBOUNCE_CYCLES, 1000000, consecutive stable clk cycles required to accept a new level; legal range ≥1.
- INVERT_MASK, 0, WIDTH-bit mask; a 1 inverts that channel's raw input before synchronization (active-low buttons).
- REPEAT_DELAY, 50000000, cycles held before the first auto-repeat pulse (used only with AUTO_REPEAT_EN).
- REPEAT_PERIOD, 10000000, cycles between subsequent auto-repeat pulses (used only with AUTO_REPEAT_EN).

Ports:
- clk  input  1  system clock, same clock that drives the clock divider.
- clr  input  1  asynchronous, active-low reset; 0 resets all state immediately.
- raw_in  input  WIDTH  asynchronous board inputs.
- level  output  WIDTH  debounced level per channel.
- rise  output  WIDTH  one-cycle pulse when level goes 0→1 (also repeat pulses when enabled).
- fall  output  WIDTH  one-cycle pulse when level goes 1→0.

Behaviour:
- Reset (clr=0, async):
  - Synchronizer flops, counters, level, rise and fall all go to 0.
  - Repeat counters also go to 0.
  - After clr deasserts, no rise pulse is produced for inputs already low after inversion.
  - An input held high after inversion through reset produces a normal rise after debounce.
- Input path per channel: x = raw_in ^ INVERT_MASK feeds a 2-flop synchronizer (s1, s2).
- Debounce counter:
  - Width is clog2(DEBOUNCE_CYCLES+1), saturating.
  - On each clk edge where s2 != level, the counter increments.
  - On each clk edge where s2 == level, the counter clears to 0. Any glitch shorter than DEBOUNCE_CYCLES restarts qualification.
  - On the edge where s2 != level and counter == DEBOUNCE_CYCLES-1:
    - level toggles;
    - counter clears;
    - the matching rise or fall bit is 1 for exactly that following cycle.
- Latency: a clean raw transition settled before edge 1 is visible on level/rise/fall after edge DEBOUNCE_CYCLES+2. With DEBOUNCE_CYCLES=1 this is 3 edges.
- rise and fall are registered outputs. They are never both 1 for a channel, and are 0 in every cycle without a qualifying event.
- Channels are independent. Simultaneous events on several channels produce simultaneous pulses.
- A reset asserted mid-qualification discards the count. No pulse is emitted on release of reset.

Optional Feature:
- Macro: INPUT_CONDITIONER_AUTO_REPEAT_EN.
- Defined:
  - Each channel has a hold counter that counts while level=1 and clears when level=0 or on reset.
  - After REPEAT_DELAY cycles of level=1 following the rise, an extra one-cycle rise pulse is emitted.
  - Further rise pulses follow every REPEAT_PERIOD cycles while level stays 1.
  - Repeat stops on the same edge level falls; fall behaves normally.
- Undefined: no hold counters are built; exactly one rise pulse per debounced press.

Test Plan (WIDTH=4, DEBOUNCE_CYCLES=4, INVERT_MASK=4'b0010):
- Reset then idle raw_in=4'b0010 (ch1 inverted, so x=0 everywhere) → level=0, rise=0, fall=0 for 20 cycles after clr=1.
- raw_in[0] 0→1 held → level[0]=1 and rise[0]=1 for exactly one cycle after edge 6; no other bits change.
- raw_in[2] pulses high 3 cycles then low (bounce) → level[2] stays 0, no rise; then held high 10 cycles → rise[2] once, 6 edges after the final rising transition.
- raw_in[1] 1→0 (inverted press) → rise[1] after 6 edges; back to 1 → fall[1] after 6 edges; rise[1] and fall[1] never coincide.
- clr pulsed low 2 cycles into qualifying raw_in[3]=1, then released with raw_in[3] still 1 → no pulse during reset; rise[3] 6 edges after clr=1, level[3]=1.
- With INPUT_CONDITIONER_AUTO_REPEAT_EN, REPEAT_DELAY=10, REPEAT_PERIOD=5, raw_in[0] held 30 cycles:
  - rise[0] pulses at debounce acceptance, then +10 and every +5 thereafter while held;
  - none after fall[0].

Source files
------------

// File: rtl/input_conditioner.sv
// input_conditioner: per-channel 2-flop sync + debounce of raw board inputs; registered level and 1-cycle rise/fall pulses.
// Latency DEBOUNCE_CYCLES+2 edges; no backpressure. Define INPUT_CONDITIONER_AUTO_REPEAT_EN for held-key rise auto-repeat.
module input_conditioner #(
  parameter int               WIDTH           = 8,
  parameter int               DEBOUNCE_CYCLES = 1000000,
  parameter logic [WIDTH-1:0] INVERT_MASK     = '0,
  parameter int               REPEAT_DELAY    = 50000000,
  parameter int               REPEAT_PERIOD   = 10000000
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("input_conditioner: cycle-count parameters must be >= 1");
  end

  logic [WIDTH-1:0] s1, s2;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw_in ^ INVERT_MASK;
      s2 <= s1;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    logic [CW-1:0] cnt;
    logic          lvl_q, rise_q, fall_q;
    logic          differ, accept, rep_hit;

    assign differ = (s2[i] != lvl_q);
    assign accept = differ && (cnt == CNT_LAST);

    // Reaching CNT_LAST while still differing always accepts, so cnt never wraps.
    always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
        cnt <= '0;
      end else if (!differ || accept) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
        lvl_q  <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        lvl_q  <= lvl_q ^ accept;
        rise_q <= (accept & ~lvl_q) | rep_hit;
        fall_q <= accept & lvl_q;
      end
    end

`ifdef INPUT_CONDITIONER_AUTO_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HW   = $clog2(RMAX + 1);

    logic [HW-1:0] hold;
    logic          rep_phase;

    // First repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD; suppressed on the falling edge.
    assign rep_hit = lvl_q && !accept &&
                     (hold == (rep_phase ? HW'(REPEAT_PERIOD - 1) : HW'(REPEAT_DELAY - 1)));

    always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
        hold      <= '0;
        rep_phase <= 1'b0;
      end else if (!lvl_q || accept) begin
        hold      <= '0;
        rep_phase <= 1'b0;
      end else if (rep_hit) begin
        hold      <= '0;
        rep_phase <= 1'b1;
      end else begin
        hold      <= hold + 1'b1;
      end
    end
`else
    assign rep_hit = 1'b0;
`endif

    assign level[i] = lvl_q;
    assign rise[i]  = rise_q;
    assign fall[i]  = fall_q;
  end

endmodule
